// File: rtl/ddr2_line_fetch.sv
// Line-fetch requester for ddr2_mgr: sweeps rows 0..MAX_ROW one line per request and forwards beats as pixels.
// Define DDR2_LINE_FETCH_CHECK_EN to compile the beat-pattern checker (data_fault / err_cnt).
module ddr2_line_fetch #(
   parameter logic [12:0] MAX_ROW   = 13'h02FF,
   parameter logic [9:0]  XFR_LEN   = 10'h200,
   parameter logic [31:0] EXP_DATA  = 32'hFDCB8610,
   parameter int unsigned WDOG_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   output logic        rd_mem_req,
   output logic [24:0] rd_mem_addr,
   output logic [9:0]  rd_xfr_len,
   input  logic        rd_mem_grant,
   input  logic [31:0] rd_data,
   input  logic        rd_data_valid,
   output logic [31:0] px_data,
   output logic        px_valid,
   output logic        line_done,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic        proto_fault,
   output logic        wdog_fault,
   output logic        data_fault,
   output logic [15:0] err_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      XFER,
      DONE
   } state_t;

   localparam logic [WDOG_BITS-1:0] WDOG_LAST = {{(WDOG_BITS-1){1'b1}}, 1'b0};
   localparam logic [WDOG_BITS-1:0] WDOG_ONE  = {{(WDOG_BITS-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               state_nxt;
   logic [12:0]          row;
   logic [12:0]          row_nxt;
   logic [9:0]           beat_cnt;
   logic [9:0]           beat_inc;
   logic [WDOG_BITS-1:0] wdog_cnt;
   logic                 stop_pend;
   logic                 active;
   logic                 beat_ok;
   logic                 progress;
   logic                 wdog_exp;
   logic                 row_wrap;
   logic                 req_entry;

   always_comb begin
      active    = (state == REQ) || (state == WAIT_DATA) || (state == XFER);
      beat_ok   = rd_data_valid && ((state == WAIT_DATA) || (state == XFER));
      progress  = rd_mem_grant || beat_ok;
      wdog_exp  = active && !progress && (wdog_cnt == WDOG_LAST);
      beat_inc  = beat_cnt + 10'd1;
      row_wrap  = (row == MAX_ROW);
      state_nxt = state;
      row_nxt   = row;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = REQ;
               row_nxt   = '0;
            end
         end
         REQ: begin
            if (rd_mem_grant) state_nxt = WAIT_DATA;
         end
         WAIT_DATA, XFER: begin
            if (rd_data_valid) state_nxt = (beat_inc == XFR_LEN) ? DONE : XFER;
         end
         DONE: begin
            state_nxt = (stop_pend || stop) ? IDLE : REQ;
            row_nxt   = row_wrap ? '0 : row + 13'd1;
         end
         default: state_nxt = IDLE;
      endcase
      if (wdog_exp) state_nxt = IDLE;
      req_entry = (state_nxt == REQ) && (state != REQ);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row         <= '0;
         beat_cnt    <= '0;
         wdog_cnt    <= '0;
         stop_pend   <= 1'b0;
         rd_mem_req  <= 1'b0;
         rd_mem_addr <= '0;
         rd_xfr_len  <= '0;
         px_data     <= '0;
         px_valid    <= 1'b0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
         proto_fault <= 1'b0;
         wdog_fault  <= 1'b0;
      end else begin
         state      <= state_nxt;
         row        <= row_nxt;
         rd_mem_req <= (state_nxt == REQ);
         rd_xfr_len <= (state_nxt == REQ) ? XFR_LEN : '0;
         busy       <= (state_nxt != IDLE);
         line_done  <= (state_nxt == DONE);
         frame_done <= (state_nxt == DONE) && row_wrap;
         px_valid   <= beat_ok;
         if (beat_ok) px_data <= rd_data;
         if (req_entry) rd_mem_addr <= {row_nxt, 10'd0, 2'd0};

         if (req_entry) beat_cnt <= '0;
         else if (beat_ok) beat_cnt <= beat_inc;

         // Any state change counts as progress, so the watchdog restarts on entry.
         if (!active || progress || (state_nxt != state)) wdog_cnt <= '0;
         else wdog_cnt <= wdog_cnt + WDOG_ONE;

         if (state_nxt == IDLE) stop_pend <= 1'b0;
         else if (stop && (state != IDLE)) stop_pend <= 1'b1;

         if ((state_nxt == DONE) && row_wrap && (frame_cnt != '1)) frame_cnt <= frame_cnt + 16'd1;
         if (rd_data_valid && !beat_ok) proto_fault <= 1'b1;
         if (wdog_exp) wdog_fault <= 1'b1;
      end
   end

`ifdef DDR2_LINE_FETCH_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         data_fault <= 1'b0;
         err_cnt    <= '0;
      end else if (beat_ok && (rd_data != EXP_DATA)) begin
         data_fault <= 1'b1;
         if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      end
   end
`else
   logic unused_exp_data;
   assign unused_exp_data = ^EXP_DATA;
   assign data_fault      = 1'b0;
   assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_ddr2_line_fetch.sv
// Randomized bench for ddr2_line_fetch: reactive ddr2_mgr responder plus a line-level behavioural model
// compared every cycle, with hand-computed checks for reset, stop, watchdog, checker and mid-line reset.
module tb_ddr2_line_fetch;
   localparam logic [12:0] MAX_ROW    = 13'd3;
   localparam logic [9:0]  XFR_LEN    = 10'd5;
   localparam logic [31:0] EXP_DATA   = 32'hFDCB8610;
   localparam int unsigned WDOG_BITS  = 12;
   localparam int          WDOG_LIMIT = (1 << WDOG_BITS) - 1;
`ifdef DDR2_LINE_FETCH_CHECK_EN
   localparam logic        CHECK_ON   = 1'b1;
`else
   localparam logic        CHECK_ON   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        rd_mem_grant = 1'b0;
   logic        rd_data_valid = 1'b0;
   logic [31:0] rd_data = '0;
   logic        rd_mem_req;
   logic [24:0] rd_mem_addr;
   logic [9:0]  rd_xfr_len;
   logic [31:0] px_data;
   logic        px_valid;
   logic        line_done;
   logic        frame_done;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        proto_fault;
   logic        wdog_fault;
   logic        data_fault;
   logic [15:0] err_cnt;

   int checks = 0;
   int failures = 0;

   ddr2_line_fetch #(
      .MAX_ROW(MAX_ROW),
      .XFR_LEN(XFR_LEN),
      .EXP_DATA(EXP_DATA),
      .WDOG_BITS(WDOG_BITS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .rd_mem_req(rd_mem_req), .rd_mem_addr(rd_mem_addr), .rd_xfr_len(rd_xfr_len),
      .rd_mem_grant(rd_mem_grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .px_data(px_data), .px_valid(px_valid), .line_done(line_done), .frame_done(frame_done),
      .busy(busy), .frame_cnt(frame_cnt), .proto_fault(proto_fault), .wdog_fault(wdog_fault),
      .data_fault(data_fault), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Line-level model: tracks whether a fetch is running, whether the grant is still owed,
   // beats received in the line, and cycles since the last sign of progress.
   bit          m_run = 0, m_wait_gnt = 0, m_done = 0, m_stop = 0;
   int          m_beats = 0, m_row = 0, m_quiet = 0;
   logic        e_req = 0, e_pxv = 0, e_ld = 0, e_fd = 0, e_busy = 0;
   logic        e_proto = 0, e_wdog = 0, e_dfault = 0;
   logic [24:0] e_addr = '0;
   logic [9:0]  e_len = '0;
   logic [31:0] e_pxd = '0;
   logic [15:0] e_fcnt = '0, e_err = '0;

   always @(posedge clk) begin
      bit taking;
      bit beat_ok;
      if (rst) begin
         m_run = 0; m_wait_gnt = 0; m_done = 0; m_stop = 0;
         m_beats = 0; m_row = 0; m_quiet = 0;
         e_pxv = 0; e_ld = 0; e_fd = 0; e_proto = 0; e_wdog = 0; e_dfault = 0;
         e_addr = '0; e_pxd = '0; e_fcnt = '0; e_err = '0;
      end else begin
         taking  = m_run && !m_done && !m_wait_gnt;
         beat_ok = rd_data_valid && taking;
         e_pxv   = beat_ok;
         if (beat_ok) e_pxd = rd_data;
         if (rd_data_valid && !taking) e_proto = 1;
         if (CHECK_ON && beat_ok && (rd_data != EXP_DATA)) begin
            e_dfault = 1;
            if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
         end
         e_ld = 0;
         e_fd = 0;
         if (!m_run) begin
            if (start) begin
               m_run = 1; m_wait_gnt = 1; m_done = 0; m_beats = 0;
               m_row = 0; m_quiet = 0; m_stop = 0; e_addr = '0;
            end
         end else if (m_done) begin
            m_done = 0;
            m_row  = (m_row == int'(MAX_ROW)) ? 0 : m_row + 1;
            if (m_stop || stop) begin
               m_run = 0; m_stop = 0;
            end else begin
               m_wait_gnt = 1; m_beats = 0; m_quiet = 0;
               e_addr = {13'(m_row), 12'd0};
            end
         end else begin
            if (stop) m_stop = 1;
            if (m_wait_gnt && rd_mem_grant) m_wait_gnt = 0;
            if (beat_ok) m_beats++;
            if (m_beats == int'(XFR_LEN)) begin
               m_done = 1; e_ld = 1;
               if (m_row == int'(MAX_ROW)) begin
                  e_fd = 1;
                  if (e_fcnt != 16'hFFFF) e_fcnt = e_fcnt + 16'd1;
               end
            end else if (rd_mem_grant || beat_ok) begin
               m_quiet = 0;
            end else begin
               m_quiet++;
               if (m_quiet == WDOG_LIMIT) begin
                  e_wdog = 1; m_run = 0; m_stop = 0;
               end
            end
         end
      end
      e_req  = m_run && m_wait_gnt && !m_done;
      e_len  = e_req ? XFR_LEN : '0;
      e_busy = m_run;
   end

   always @(negedge clk) begin
      chk("rd_mem_req", rd_mem_req, e_req);
      chk("rd_mem_addr", rd_mem_addr, e_addr);
      chk("rd_xfr_len", rd_xfr_len, e_len);
      chk("px_valid", px_valid, e_pxv);
      if (e_pxv) chk("px_data", px_data, e_pxd);
      chk("line_done", line_done, e_ld);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, e_busy);
      chk("frame_cnt", frame_cnt, e_fcnt);
      chk("proto_fault", proto_fault, e_proto);
      chk("wdog_fault", wdog_fault, e_wdog);
      chk("data_fault", data_fault, e_dfault);
      chk("err_cnt", err_cnt, e_err);
   end

   // ddr2_mgr responder state
   int gnt_delay = 0, beats_left = 0, sent = 0, corrupt_idx = -1;
   bit withhold = 0, rand_corrupt = 0;
   int n_ld = 0, n_px = 0;

   task automatic step(input bit st, input bit sp, input bit inj);
      @(posedge clk);
      #1;
      n_ld += int'(line_done);
      n_px += int'(px_valid);
      start = st;
      stop = sp;
      rd_mem_grant = 1'b0;
      rd_data_valid = 1'b0;
      rd_data = $urandom;
      if (rst) begin
         beats_left = 0;
         gnt_delay = 0;
      end else if (beats_left > 0) begin
         if ($urandom_range(0, 3) != 0) begin
            sent++;
            rd_data_valid = 1'b1;
            rd_data = EXP_DATA;
            if (sent == corrupt_idx) rd_data = 32'h0;
            else if (rand_corrupt && ($urandom_range(0, 7) == 0)) rd_data = $urandom;
            beats_left--;
         end
      end else if (rd_mem_req && !withhold) begin
         if (gnt_delay == 0) begin
            rd_mem_grant = 1'b1;
            beats_left = int'(XFR_LEN);
            gnt_delay = $urandom_range(0, 4);
         end else begin
            gnt_delay--;
         end
      end
      if (inj) begin
         rd_data_valid = 1'b1;
         rd_data = EXP_DATA;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) step(0, 0, 0);
      rst = 1'b0;
      chk("reset busy", busy, 0);
      chk("reset rd_mem_req", rd_mem_req, 0);
      chk("reset rd_mem_addr", rd_mem_addr, 0);
      chk("reset rd_xfr_len", rd_xfr_len, 0);
      chk("reset frame_cnt", frame_cnt, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      chk("idle stop ignored busy", busy, 0);

      // start coincident with stop in IDLE still starts; beat 17 corrupted
      corrupt_idx = 17;
      sent = 0;
      step(1, 1, 0);
      step(0, 0, 0);
      chk("start req", rd_mem_req, 1);
      chk("start addr row0", rd_mem_addr, 0);
      chk("start xfr_len", rd_xfr_len, 5);
      n_ld = 0;
      n_px = 0;
      for (int i = 0; i < 600 && n_ld < 5; i++) step(0, 0, 0);
      chk("five lines done", n_ld, 5);
      chk("frame_cnt after row 3", frame_cnt, 1);
      step(0, 0, 0);
      step(0, 1, 0);
      for (int i = 0; i < 300 && busy; i++) step(0, 0, 0);
      chk("stop completes line", n_ld, 6);
      chk("stop px beats", n_px, 30);
      chk("stop goes idle", busy, 0);
      chk("checker data_fault", data_fault, 32'(CHECK_ON));
      chk("checker err_cnt", err_cnt, 32'(CHECK_ON));
      repeat (10) step(0, 0, 0);
      chk("no request after stop", rd_mem_req, 0);
      chk("proto clean before inject", proto_fault, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("idle beat sets proto", proto_fault, 1);

      // randomized run: restarts, stops, corrupted data
      rand_corrupt = 1;
      corrupt_idx = -1;
      n_ld = 0;
      n_px = 0;
      step(1, 0, 0);
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 14) == 0), ($urandom_range(0, 99) == 0),
              (!busy && ($urandom_range(0, 9) == 0)));
      step(0, 1, 0);
      for (int i = 0; i < 300 && busy; i++) step(0, 0, 0);
      chk("random run idle", busy, 0);
      chk("random px per line", n_px, n_ld * int'(XFR_LEN));

      // watchdog: grant withheld
      withhold = 1;
      step(1, 0, 0);
      n = 0;
      while (!wdog_fault && n < 4200) begin
         step(0, 0, 0);
         n++;
      end
      chk("wdog latency", n, 4096);
      chk("wdog fault", wdog_fault, 1);
      chk("wdog req dropped", rd_mem_req, 0);
      chk("wdog idle", busy, 0);
      repeat (5) step(0, 0, 0);
      chk("wdog no auto restart", busy, 0);
      withhold = 0;
      step(1, 0, 0);
      step(0, 0, 0);
      chk("restart req", rd_mem_req, 1);
      chk("restart row0", rd_mem_addr, 0);

      // reset mid-transfer
      n = 0;
      while (!px_valid && n < 100) begin
         step(0, 0, 0);
         n++;
      end
      chk("reached xfer", px_valid, 1);
      step(0, 0, 0);
      rst = 1'b1;
      step(0, 0, 0);
      rst = 1'b0;
      chk("mid rst busy", busy, 0);
      chk("mid rst req", rd_mem_req, 0);
      chk("mid rst addr", rd_mem_addr, 0);
      chk("mid rst px_valid", px_valid, 0);
      chk("mid rst frame_cnt", frame_cnt, 0);
      chk("mid rst proto", proto_fault, 0);
      chk("mid rst wdog", wdog_fault, 0);
      chk("mid rst err_cnt", err_cnt, 0);
      repeat (5) step(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
